// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer and its ALU handshake.
package muldiv_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration, given the ALU's answer for this cycle.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shf,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             carry,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] shf_nxt
);

    always_comb begin
        acc_nxt = acc;
        shf_nxt = shf;
        if (is_div) begin
            // acc[WIDTH-1] is the shifted-out bit r[WIDTH]: the partial remainder
            // then exceeds WIDTH bits, so the subtraction always fits.
            if (acc[WIDTH-1] || !carry) begin
                acc_nxt = alu_out;
                shf_nxt = {shf[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[WIDTH-2:0], shf[WIDTH-1]};
                shf_nxt = {shf[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (shf[0]) begin
                acc_nxt = {carry, alu_out[WIDTH-1:1]};
                shf_nxt = {alu_out[0], shf[WIDTH-1:1]};
            end else begin
                acc_nxt = {1'b0, acc[WIDTH-1:1]};
                shf_nxt = {acc[0], shf[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer driving a shared external ALU,
// one iteration per clock, with a registered result and one-cycle done pulse.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_flags
);

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] count;
    // acc holds hi (multiply) or rem (divide); shf holds lo or quo; opnd holds mcand or dvsr.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shf;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] shf_nxt;
    logic             is_div;
    logic             last_step;
    logic             unused_flags;

    assign is_div       = op_q[1];
    assign last_step    = (count == CNT_W'(WIDTH - 1));
    assign unused_flags = ^{alu_flags[FLAG_Z], alu_flags[FLAG_S], alu_flags[FLAG_V]};

    function automatic logic [WIDTH-1:0] select_result(
        input logic [1:0]       sel_op,
        input logic [WIDTH-1:0] hi_rem,
        input logic [WIDTH-1:0] lo_quo
    );
        case (sel_op)
            OP_MUL:   return lo_quo;
            OP_MULHU: return hi_rem;
            OP_DIVU:  return lo_quo;
            default:  return hi_rem;
        endcase
    endfunction

    // ALU requests come only from registered state, never from start.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        if (state == RUN) begin
            alu_b = opnd;
            if (is_div) begin
                alu_a    = {acc[WIDTH-2:0], shf[WIDTH-1]};
                alu_ctrl = ALU_SUB;
            end else begin
                alu_a = acc;
            end
        end
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div (is_div),
        .acc    (acc),
        .shf    (shf),
        .alu_out(alu_out),
        .carry  (alu_flags[FLAG_C]),
        .acc_nxt(acc_nxt),
        .shf_nxt(shf_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            count  <= '0;
            acc    <= '0;
            shf    <= '0;
            opnd   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        count <= '0;
                        if (!op[1]) begin
                            acc   <= '0;
                            shf   <= src2;
                            opnd  <= src1;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else if (src2 != '0) begin
                            acc   <= '0;
                            shf   <= src1;
                            opnd  <= src2;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            // Divide by zero completes immediately with the RV32 M results.
                            result <= (op == OP_DIVU) ? {WIDTH{1'b1}} : src1;
                            done   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    shf   <= shf_nxt;
                    count <= count + 1'b1;
                    if (last_step) begin
                        result <= select_result(op_q, acc_nxt, shf_nxt);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_out;
    logic [3:0]   alu_flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out),
        .alu_flags(alu_flags)
    );

    // Shared ALU: ADD/SUB with {zero, sign, carry/borrow, overflow}.
    always_comb begin
        logic [W:0] sum;
        logic       c;
        logic       v;
        if (alu_ctrl == 4'b0001) begin
            sum = {1'b0, alu_a} - {1'b0, alu_b};
            c   = (alu_a < alu_b);
            v   = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        end else begin
            sum = {1'b0, alu_a} + {1'b0, alu_b};
            c   = sum[W];
            v   = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        end
        alu_out   = sum[W-1:0];
        alu_flags = {(sum[W-1:0] == '0), sum[W-1], c, v};
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then sample on negedges until done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat, output int busy_cnt,
                          output logic busy_at_done);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(negedge clk);
        start = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        busy_at_done = busy;
        res          = result;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout: no done after %0d cycles (op %0d)", lat, o);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           dz;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [W-1:0] res;
        int           lat;
        int           bcnt;
        logic         bdone;
        int           pulses;

        vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0};
        vecs[4]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0};
        vecs[5]  = '{2'b10, 32'd100,       32'd7,         32'h0000_000E, 1'b0};
        vecs[6]  = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 1'b0};
        vecs[7]  = '{2'b10, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1};
        vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src1  = '0;
        src2  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   {31'b0, busy}, 32'd0);
        check("reset_done",   {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_alu_a",  alu_a, 32'd0);
        check("reset_alu_b",  alu_b, 32'd0);
        check("reset_ctrl",   {28'b0, alu_ctrl}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt, bdone);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].dz ? 32'd1 : 32'd33);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].dz ? 32'd0 : 32'd32);
            check($sformatf("vec%0d_busy_at_done", i), {31'b0, bdone}, 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_done_clears", i), {31'b0, done}, 32'd0);
        end

        // Reset during iteration 10 of a MUL aborts silently.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        src1  = 32'd7;
        src2  = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   {31'b0, busy}, 32'd0);
        check("abort_done",   {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort_no_done", pulses, 32'd0);

        // Start while busy is ignored; original MUL result survives.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        src1  = 32'd7;
        src2  = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        src1  = 32'd100;
        src2  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat   = 6;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("busy_start_latency", lat, 32'd33);
        check("busy_start_result", result, 32'h0000_002A);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("busy_start_not_latched", pulses, 32'd0);
        check("busy_start_result_held", result, 32'h0000_002A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
